// File: rtl/fp_pkg.sv
// Shared definitions for the 8-bit float (S, E[2:0], F[3:0]) datapath.
// Holds the word widths used by both the encoder and the expander, and the
// expander's FSM state encoding.
package fp_pkg;

  localparam int unsigned DW = 12;  // two's-complement output width
  localparam int unsigned EW = 3;   // exponent width
  localparam int unsigned FW = 4;   // significand width

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StShift = 2'd1,
    StSign  = 2'd2,
    StDone  = 2'd3
  } state_e;

endpackage

// File: rtl/sign_mag_to_twos.sv
// Combinational sign-magnitude to two's-complement conversion.
// Ports:
//   sgn - sign bit (1 = negative)
//   mag - unsigned magnitude
//   val - two's-complement result; a zero magnitude always yields zero
module sign_mag_to_twos #(
  parameter int unsigned W = 12
) (
  input  logic         sgn,
  input  logic [W-1:0] mag,
  output logic [W-1:0] val
);

  always_comb begin
    val = sgn ? (~mag + W'(1)) : mag;
  end

endmodule

// File: rtl/fp_expand.sv
// Expands an 8-bit float (S, E, F) into a DW-bit two's-complement value
// V = (-1)^S * F * 2^E using a one-bit-per-clock shifter.
// Ports:
//   clk, rst              - clock and synchronous active-high reset
//   in_valid, in_ready    - input handshake; accepted only while idle
//   S, E, F               - sign, exponent (shift count), significand
//   out_valid, out_ready  - output handshake; result held until taken
//   D                     - decoded value, meaningful while out_valid=1
module fp_expand #(
  parameter int unsigned DW = fp_pkg::DW,
  parameter int unsigned EW = fp_pkg::EW,
  parameter int unsigned FW = fp_pkg::FW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic          S,
  input  logic [EW-1:0] E,
  input  logic [FW-1:0] F,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] D
);

  import fp_pkg::*;

  state_e        state_q, state_d;
  logic [DW-1:0] mag_q, mag_d;
  logic [EW-1:0] cnt_q, cnt_d;
  logic          sgn_q, sgn_d;
  logic [DW-1:0] d_q, d_d;
  logic [DW-1:0] twos;

  sign_mag_to_twos #(
    .W (DW)
  ) u_sign (
    .sgn (sgn_q),
    .mag (mag_q),
    .val (twos)
  );

  always_comb begin
    state_d = state_q;
    mag_d   = mag_q;
    cnt_d   = cnt_q;
    sgn_d   = sgn_q;
    d_d     = d_q;
    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          mag_d   = {{(DW-FW){1'b0}}, F};
          cnt_d   = E;
          sgn_d   = S;
          state_d = StShift;
        end
      end
      StShift: begin
        // The zero-count cycle is spent here too, so latency depends only on E.
        if (cnt_q == '0) begin
          state_d = StSign;
        end else begin
          mag_d = mag_q << 1;
          cnt_d = cnt_q - EW'(1);
        end
      end
      StSign: begin
        d_d     = twos;
        state_d = StDone;
      end
      StDone: begin
        if (out_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      mag_q   <= '0;
      cnt_q   <= '0;
      sgn_q   <= 1'b0;
      d_q     <= '0;
    end else begin
      state_q <= state_d;
      mag_q   <= mag_d;
      cnt_q   <= cnt_d;
      sgn_q   <= sgn_d;
      d_q     <= d_d;
    end
  end

  assign in_ready  = (state_q == StIdle);
  assign out_valid = (state_q == StDone);
  assign D         = d_q;

endmodule

// File: tb/tb_fp_expand.sv
module tb_fp_expand;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic        S;
  logic [2:0]  E;
  logic [3:0]  F;
  logic        out_valid;
  logic        out_ready;
  logic [11:0] D;

  int errors = 0;
  int checks = 0;
  logic [11:0] last_d = 12'h000;

  fp_expand dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .S         (S),
    .E         (E),
    .F         (F),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .D         (D)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference: signed integer arithmetic, truncated to the 12-bit output word.
  function automatic logic [11:0] ref_val(input logic s, input logic [2:0] e,
                                          input logic [3:0] f);
    int v;
    v = int'(f) * (1 << int'(e));
    if (s) v = -v;
    return v[11:0];
  endfunction

  // One transaction, entered and left at a negedge with the DUT idle.
  task automatic run_one(input logic s, input logic [2:0] e, input logic [3:0] f,
                         input int stall, input bit noise, input string tag);
    logic [11:0] exp_d;
    int lat;
    bit seen;
    exp_d = ref_val(s, e, f);
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s in_ready_idle: got %b want 1", tag, in_ready);
    end
    in_valid  = 1'b1;
    S         = s;
    E         = e;
    F         = f;
    out_ready = (stall == 0);
    @(posedge clk);
    @(negedge clk);
    // New values after the accept edge must have no effect.
    in_valid = noise;
    S = 1'($urandom);
    E = 3'($urandom);
    F = 4'($urandom);
    lat  = 0;
    seen = 1'b0;
    while (!seen && lat < 16) begin
      checks++;
      if (D !== last_d) begin
        errors++;
        $display("FAIL %s d_hold_busy: got %h want %h", tag, D, last_d);
      end
      checks++;
      if (in_ready !== 1'b0) begin
        errors++;
        $display("FAIL %s in_ready_busy: got %b want 0", tag, in_ready);
      end
      @(posedge clk);
      lat++;
      @(negedge clk);
      if (noise) begin
        S = 1'($urandom);
        E = 3'($urandom);
        F = 4'($urandom);
      end
      seen = (out_valid === 1'b1);
    end
    in_valid = 1'b0;
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL %s out_valid_timeout: got none after %0d cycles want %0d", tag, lat,
               int'(e) + 2);
      return;
    end else if (lat != int'(e) + 2) begin
      errors++;
      $display("FAIL %s latency: got %0d want %0d", tag, lat, int'(e) + 2);
    end
    checks++;
    if (D !== exp_d) begin
      errors++;
      $display("FAIL %s data: got %h want %h (S=%b E=%0d F=%h)", tag, D, exp_d, s, e, f);
    end
    last_d = exp_d;
    for (int i = 0; i < stall; i++) begin
      @(posedge clk);
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b1 || D !== exp_d || in_ready !== 1'b0) begin
        errors++;
        $display("FAIL %s backpressure_hold: got v=%b rdy=%b D=%h want v=1 rdy=0 D=%h",
                 tag, out_valid, in_ready, D, exp_d);
      end
    end
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s release: got v=%b rdy=%b want v=0 rdy=1", tag, out_valid, in_ready);
    end
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || D !== 12'h000) begin
      errors++;
      $display("FAIL reset_state: got v=%b rdy=%b D=%h want v=0 rdy=1 D=000",
               out_valid, in_ready, D);
    end
    rst = 1'b0;
    last_d = 12'h000;
  endtask

  task automatic test_directed();
    run_one(1'b0, 3'd0, 4'b0101, 0, 1'b0, "e0_min_latency");
    run_one(1'b0, 3'd7, 4'b1111, 0, 1'b0, "max_positive");
    run_one(1'b1, 3'd7, 4'b1111, 0, 1'b0, "max_negative");
    run_one(1'b1, 3'd3, 4'b1010, 0, 1'b0, "neg_80");
    run_one(1'b1, 3'd5, 4'b0000, 0, 1'b0, "neg_zero");
    run_one(1'b0, 3'd4, 4'b0000, 0, 1'b0, "pos_zero");
  endtask

  task automatic test_backpressure();
    run_one(1'b0, 3'd2, 4'b0011, 6, 1'b0, "backpressure");
  endtask

  task automatic test_busy_drop();
    run_one(1'b0, 3'd4, 4'b1001, 2, 1'b1, "busy_drop");
    run_one(1'b1, 3'd1, 4'b0111, 0, 1'b0, "after_busy_drop");
  endtask

  task automatic test_reset_mid_shift();
    in_valid = 1'b1;
    S = 1'b0;
    E = 3'd6;
    F = 4'b1101;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk);
      @(negedge clk);
    end
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || D !== 12'h000) begin
      errors++;
      $display("FAIL reset_mid_shift: got v=%b rdy=%b D=%h want v=0 rdy=1 D=000",
               out_valid, in_ready, D);
    end
    last_d = 12'h000;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
        errors++;
        $display("FAIL reset_no_stale: got v=%b rdy=%b want v=0 rdy=1", out_valid, in_ready);
      end
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 80; n++) begin
      run_one(1'($urandom), 3'($urandom), 4'($urandom), int'($urandom_range(0, 3)),
              1'($urandom), "random");
    end
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    S         = 1'b0;
    E         = 3'd0;
    F         = 4'd0;
    @(negedge clk);
    test_reset();
    test_directed();
    test_backpressure();
    test_busy_drop();
    test_reset_mid_shift();
    run_one(1'b1, 3'd2, 4'b0110, 0, 1'b0, "after_reset");
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
